can_crc_sequencer: RTL and testbench

CAN_CRC_SEQUENCER -- requirements
Module: can_crc_sequencer

---
 rtl/can_crc_pkg.sv | 42 ++++
 rtl/can_crc_sequencer_edge.sv | 24 ++
 rtl/can_crc_sequencer.sv | 128 ++++++++++++
 tb/tb_can_crc_sequencer.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/can_crc_pkg.sv
// Shared types, constants and helpers for the CAN CRC-15 sequencer.
// Holds the FSM state enum, CRC geometry and DLC field positions.
package can_crc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    RECV  = 2'd2,
    CHECK = 2'd3
  } state_t;

  localparam int          CRC_W        = 15;
  localparam logic [14:0] CRC_POLY_DEF = 15'h4599;
  localparam int          HDR_LEN      = 19;
  localparam int          DLC_MSB_POS  = 15;
  localparam int          DLC_LSB_POS  = 18;

  // One serial CRC-15 step: the x^15 term of the polynomial is implicit.
  function automatic logic [14:0] crc_step(
    input logic [14:0] crc,
    input logic        b,
    input logic [14:0] poly
  );
    logic        nxt;
    logic [14:0] r;
    nxt = b ^ crc[14];
    r   = {crc[13:0], 1'b0};
    if (nxt) r = r ^ poly;
    return r;
  endfunction

  // Bits before the CRC field: header plus clamped data bytes.
  function automatic logic [6:0] pre_len(
    input logic [3:0] dlc,
    input int         max_bytes
  );
    int n;
    n = (int'(dlc) > max_bytes) ? max_bytes : int'(dlc);
    return 7'(HDR_LEN + 8 * n);
  endfunction

endpackage

// File: rtl/can_crc_sequencer_edge.sv
// Turns the sample level into a one-cycle bit_evt pulse, one cycle late.
// Ports: clk, rst (async high), sample (level in), bit_evt (pulse out).
module bit_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic sample,
  output logic bit_evt
);

  // low_seen resets to 0 so a sample already high at reset release
  // must drop and rise again before it can produce an event.
  logic low_seen;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      low_seen <= 1'b0;
      bit_evt  <= 1'b0;
    end else begin
      low_seen <= ~sample;
      bit_evt  <= sample & low_seen;
    end
  end

endmodule

// File: rtl/can_crc_sequencer.sv
// CAN CRC-15 sequencer: accumulates CRC over SOF..data, then receives
// and compares the transmitted CRC field.
// Ports: clk, rst, sample, rx_bit, stuff_bit, sof, abort (in);
//        busy, crc_value[14:0], crc_ok, crc_err (out).
module can_crc_sequencer
  import can_crc_pkg::*;
#(
  parameter logic [14:0] CRC_POLY       = CRC_POLY_DEF,
  parameter int          MAX_DATA_BYTES = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sample,
  input  logic        rx_bit,
  input  logic        stuff_bit,
  input  logic        sof,
  input  logic        abort,
  output logic        busy,
  output logic [14:0] crc_value,
  output logic        crc_ok,
  output logic        crc_err
);

  state_t      state, nxt_state;
  logic        bit_evt;
  logic        bit_q;
  logic        stuff_q;
  logic        ev;
  logic [6:0]  cnt;
  logic [3:0]  dlc;
  logic [3:0]  dlc_eff;
  logic [6:0]  len;
  logic        last_calc;
  logic        last_recv;
  logic [14:0] crc;
  logic [14:0] rcv;

  bit_edge_detect u_edge (
    .clk     (clk),
    .rst     (rst),
    .sample  (sample),
    .bit_evt (bit_evt)
  );

  // The event fires a cycle after sample rises, when rx_bit may
  // already be gone, so hold the bus values seen while sampling.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_q   <= 1'b0;
      stuff_q <= 1'b0;
    end else if (sample) begin
      bit_q   <= rx_bit;
      stuff_q <= stuff_bit;
    end
  end

  assign ev = bit_evt & ~stuff_q;

  // The last DLC bit is not yet in dlc when it is consumed; with
  // DLC=0 that same bit also ends the header, so fold it in here.
  assign dlc_eff = (cnt == 7'(DLC_LSB_POS)) ?
                   {dlc[3:1], bit_q} : dlc;
  assign len       = pre_len(dlc_eff, MAX_DATA_BYTES);
  assign last_calc = (cnt == len - 7'd1);
  assign last_recv = (cnt == 7'(CRC_W - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nxt_state;
  end

  always_comb begin
    nxt_state = state;
    if (abort) begin
      nxt_state = IDLE;
    end else begin
      case (state)
        IDLE:  if (sof) nxt_state = CALC;
        CALC:  if (ev && last_calc) nxt_state = RECV;
        RECV:  if (ev && last_recv) nxt_state = CHECK;
        CHECK: nxt_state = IDLE;
        default: nxt_state = IDLE;
      endcase
    end
  end

  always_comb begin
    busy    = (state != IDLE);
    crc_ok  = 1'b0;
    crc_err = 1'b0;
    if (state == CHECK && !abort) begin
      crc_ok  = (rcv == crc);
      crc_err = (rcv != crc);
    end
  end

  // cnt indexes frame bits in CALC and is reused for the CRC field.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      dlc <= '0;
      crc <= '0;
      rcv <= '0;
    end else if (abort) begin
      cnt <= cnt;
    end else if (state == IDLE) begin
      if (sof) begin
        cnt <= '0;
        dlc <= '0;
        crc <= '0;
        rcv <= '0;
      end
    end else if (ev) begin
      if (state == CALC) begin
        crc <= crc_step(crc, bit_q, CRC_POLY);
        cnt <= last_calc ? 7'd0 : cnt + 7'd1;
        if (cnt >= 7'(DLC_MSB_POS) && cnt <= 7'(DLC_LSB_POS))
          dlc[2'(DLC_LSB_POS - int'(cnt))] <= bit_q;
      end else if (state == RECV) begin
        rcv <= {rcv[13:0], bit_q};
        cnt <= cnt + 7'd1;
      end
    end
  end

  assign crc_value = crc;

endmodule

// File: tb/tb_can_crc_sequencer.sv
// Directed bench for can_crc_sequencer.
// Frames are bit queues; reference CRC uses augmented long division.
module tb_can_crc_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        sample;
  logic        rx_bit;
  logic        stuff_bit;
  logic        sof;
  logic        abort;
  logic        busy;
  logic [14:0] crc_value;
  logic        crc_ok;
  logic        crc_err;

  int errors = 0;
  int checks = 0;

  int   ok_cnt, err_cnt, both_cnt;
  logic pulse_busy, after_busy, prev_p;

  always #5 clk = ~clk;

  can_crc_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .sample    (sample),
    .rx_bit    (rx_bit),
    .stuff_bit (stuff_bit),
    .sof       (sof),
    .abort     (abort),
    .busy      (busy),
    .crc_value (crc_value),
    .crc_ok    (crc_ok),
    .crc_err   (crc_err)
  );

  initial begin
    ok_cnt = 0; err_cnt = 0; both_cnt = 0;
    pulse_busy = 1'b0; after_busy = 1'b1; prev_p = 1'b0;
  end

  always @(negedge clk) begin
    if (crc_ok) ok_cnt++;
    if (crc_err) err_cnt++;
    if (crc_ok && crc_err) both_cnt++;
    if (crc_ok || crc_err) pulse_busy = busy;
    if (prev_p) after_busy = busy;
    prev_p = crc_ok || crc_err;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    ok_cnt = 0; err_cnt = 0; both_cnt = 0;
    pulse_busy = 1'b0; after_busy = 1'b1;
  endtask

  function automatic logic [14:0] crc_ref(input bit q[$], input int n);
    logic [15:0] r;
    r = 16'h0;
    for (int i = 0; i < n + 15; i++) begin
      r = {r[14:0], (i < n) ? q[i] : 1'b0};
      if (r[15]) r = r ^ 16'hC599;
    end
    return r[14:0];
  endfunction

  task automatic send_bit(input bit b, input bit s, input int hold);
    rx_bit = b; stuff_bit = s; sample = 1'b1;
    repeat (hold) @(negedge clk);
    sample = 1'b0; stuff_bit = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic send_bits(input bit q[$], input int lo, input int hi,
                           input int hold, input bit stuffing);
    for (int i = lo; i < hi; i++) begin
      send_bit(q[i], 1'b0, hold);
      if (stuffing && ((i + 1) % 5 == 0)) send_bit(1'b1, 1'b1, hold);
    end
  endtask

  task automatic pulse_sof();
    sof = 1'b1;
    @(negedge clk);
    sof = 1'b0;
  endtask

  task automatic push_val(inout bit q[$], input logic [63:0] v,
                          input int w);
    for (int i = w - 1; i >= 0; i--) q.push_back(v[i]);
  endtask

  task automatic end_check(input string tag, input bit exp_ok);
    repeat (8) @(negedge clk);
    chk({tag, "_ok"}, ok_cnt, exp_ok ? 1 : 0);
    chk({tag, "_err"}, err_cnt, exp_ok ? 0 : 1);
    chk({tag, "_both"}, both_cnt, 0);
    chk({tag, "_busy_at"}, pulse_busy, 1);
    chk({tag, "_busy_after"}, after_busy, 0);
  endtask

  initial begin
    bit          zq[$];
    bit          eq[$];
    bit          fq[$];
    bit          dq[$];
    bit          aq[$];
    logic [14:0] ref_crc;

    rst = 1'b1; sample = 1'b1; rx_bit = 1'b1; stuff_bit = 1'b0;
    sof = 1'b0; abort = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_crc", crc_value, 15'h0);
    chk("rst_ok", crc_ok, 0);
    chk("rst_err", crc_err, 0);

    // sample high across reset release must not count as a bit
    rst = 1'b0;
    repeat (2) @(negedge clk);
    pulse_sof();
    repeat (4) @(negedge clk);
    chk("post_rst_busy", busy, 1);
    chk("post_rst_no_evt", crc_value, 15'h0);
    sample = 1'b0;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    @(negedge clk);
    chk("abort_idle", busy, 0);

    for (int i = 0; i < 34; i++) zq.push_back(1'b0);

    clear_mon();
    pulse_sof();
    send_bits(zq, 0, 34, 1, 1'b0);
    end_check("zero", 1'b1);
    chk("zero_crc", crc_value, 15'h0000);

    for (int i = 0; i < 19; i++) eq.push_back(1'b0);
    push_val(eq, 64'h0080, 15);
    clear_mon();
    pulse_sof();
    send_bits(eq, 0, 34, 1, 1'b0);
    end_check("bad", 1'b0);
    chk("bad_crc", crc_value, 15'h0000);

    // long sample level; stray sof mid-frame must be ignored
    clear_mon();
    pulse_sof();
    send_bits(zq, 0, 10, 5, 1'b0);
    pulse_sof();
    send_bits(zq, 10, 34, 5, 1'b0);
    end_check("hold5", 1'b1);
    chk("hold5_crc", crc_value, 15'h0000);

    clear_mon();
    pulse_sof();
    send_bits(zq, 0, 34, 1, 1'b1);
    end_check("stuff", 1'b1);
    chk("stuff_crc", crc_value, 15'h0000);

    // DLC=F clamps to 8 bytes: 83 bits before the CRC field
    fq.push_back(1'b0);
    push_val(fq, 64'h5A3, 11);
    push_val(fq, 64'h0, 3);
    push_val(fq, 64'hF, 4);
    push_val(fq, 64'hDEADBEEF01234567, 64);
    ref_crc = crc_ref(fq, 83);
    push_val(fq, 64'(ref_crc), 15);
    clear_mon();
    pulse_sof();
    send_bits(fq, 0, 83, 1, 1'b0);
    chk("dlcf_crc", crc_value, ref_crc);
    send_bits(fq, 83, 84, 1, 1'b0);
    chk("dlcf_frozen", crc_value, ref_crc);
    chk("dlcf_busy", busy, 1);
    send_bits(fq, 84, 98, 1, 1'b0);
    end_check("dlcf", 1'b1);

    dq.push_back(1'b0);
    push_val(dq, 64'h0F0, 11);
    push_val(dq, 64'h0, 3);
    push_val(dq, 64'h1, 4);
    push_val(dq, 64'hA5, 8);
    ref_crc = crc_ref(dq, 27);
    push_val(dq, 64'(ref_crc), 15);
    clear_mon();
    pulse_sof();
    send_bits(dq, 0, 42, 1, 1'b0);
    end_check("dlc1", 1'b1);
    chk("dlc1_crc", crc_value, ref_crc);

    // abort mid-frame keeps CRC and suppresses any result pulse
    aq.push_back(1'b0);
    push_val(aq, 64'h3C5, 11);
    push_val(aq, 64'h0, 3);
    push_val(aq, 64'h4, 4);
    push_val(aq, 64'h12345678, 32);
    ref_crc = crc_ref(aq, 40);
    clear_mon();
    pulse_sof();
    send_bits(aq, 0, 40, 1, 1'b0);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_crc_kept", crc_value, ref_crc);
    send_bits(aq, 40, 51, 1, 1'b0);
    repeat (8) @(negedge clk);
    chk("abort_no_ok", ok_cnt, 0);
    chk("abort_no_err", err_cnt, 0);

    abort = 1'b1; sof = 1'b1;
    @(negedge clk);
    abort = 1'b0; sof = 1'b0;
    @(negedge clk);
    chk("abort_sof_idle", busy, 0);

    clear_mon();
    pulse_sof();
    @(negedge clk);
    chk("resof_crc0", crc_value, 15'h0000);
    send_bits(zq, 0, 34, 1, 1'b0);
    end_check("resof", 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
